// File: rtl/nexys_starship_shield_bank_pkg.sv
// Shared types for the starship shield bank.
// Holds the bank and channel state encodings and a small constant helper
// used to size the per-channel tick counter.
package nexys_starship_pkg;

  typedef enum logic {
    BANK_INIT = 1'b0,
    BANK_PLAY = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_ARMED  = 2'd1,
    CH_BROKEN = 2'd2
  } ch_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nexys_starship_shield_bank_if.sv
// Shield bank bus: break/repair controls into the bank and shield status out.
//   master : game logic side (drives requests/combos/buttons, reads status)
//   slave  : shield bank side
interface nexys_starship_shield_bank_if #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned COMBO_W  = 4,
  parameter int unsigned BREACH_W = 4
);
  logic [N_CH-1:0]         break_req;
  logic [COMBO_W-1:0]      random_hex;
  logic [COMBO_W-1:0]      hex_combo;
  logic [N_CH-1:0]         repair_btn;
  logic                    override_btn;
  logic [N_CH-1:0]         broken;
  logic [N_CH*COMBO_W-1:0] combo_flat;
  logic                    breach;
  logic [BREACH_W-1:0]     breach_cnt;

  modport master (
    output break_req, random_hex, hex_combo, repair_btn, override_btn,
    input  broken, combo_flat, breach, breach_cnt
  );

  modport slave (
    input  break_req, random_hex, hex_combo, repair_btn, override_btn,
    output broken, combo_flat, breach, breach_cnt
  );
endinterface

// File: rtl/nexys_starship_shield_ch.sv
// One shield channel: IDLE -> ARMED after ARM_TICKS timer ticks, ARMED ->
// BROKEN when granted (latching random_hex), BROKEN -> IDLE on a matching
// repair or override. A BROKEN channel that sees REPAIR_TO ticks raises
// timeout for one Clk and restarts its count while staying BROKEN.
// Ports:
//   Clk, Reset         clock, async active-high reset
//   clear              force IDLE, zero counter and combo
//   active             bank is playing (channel only evolves when set)
//   timer_tick         game time base pulse
//   grant_in           break granted by the bank this Clk
//   repair_btn         repair strobe for this channel
//   override_btn       global repair
//   random_hex         combo to latch on break
//   hex_combo          player-entered combo
//   is_armed/is_broken current state flags
//   repair_ok          repair succeeds this Clk
//   timeout            repair window expires this Clk (not when repaired)
//   combo              latched combo
module nexys_starship_shield_ch
  import nexys_starship_pkg::*;
#(
  parameter int unsigned COMBO_W   = 4,
  parameter int unsigned ARM_TICKS = 2,
  parameter int unsigned REPAIR_TO = 30
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear,
  input  logic               active,
  input  logic               timer_tick,
  input  logic               grant_in,
  input  logic               repair_btn,
  input  logic               override_btn,
  input  logic [COMBO_W-1:0] random_hex,
  input  logic [COMBO_W-1:0] hex_combo,
  output logic               is_armed,
  output logic               is_broken,
  output logic               repair_ok,
  output logic               timeout,
  output logic [COMBO_W-1:0] combo
);

  localparam int unsigned CNT_MAX = max_u(ARM_TICKS, REPAIR_TO);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPAIR_TO - 1);

  ch_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COMBO_W-1:0] combo_q, combo_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      combo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      combo_q <= combo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    combo_d = combo_q;
    if (clear) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
      combo_d = '0;
    end else if (active) begin
      unique case (state_q)
        CH_IDLE: begin
          if (timer_tick) begin
            if (cnt_q == ARM_LAST) begin
              state_d = CH_ARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        CH_ARMED: begin
          if (grant_in) begin
            state_d = CH_BROKEN;
            combo_d = random_hex;
            cnt_d   = '0;
          end
        end
        CH_BROKEN: begin
          // Repair takes precedence over an expiring window on the same Clk.
          if (repair_ok) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
          end else if (timer_tick) begin
            cnt_d = (cnt_q == REP_LAST) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    is_armed  = (state_q == CH_ARMED);
    is_broken = (state_q == CH_BROKEN);
    repair_ok = is_broken && active &&
                (override_btn || (repair_btn && (hex_combo == combo_q)));
    timeout   = is_broken && active && timer_tick && (cnt_q == REP_LAST) && !repair_ok;
    combo     = combo_q;
  end

endmodule

// File: rtl/nexys_starship_shield_bank.sv
// N-channel shield controller. Holds the INIT/PLAY bank FSM, grants new
// breaks lowest-index-first within the MAX_BROKEN budget, and turns channel
// timeouts into a breach pulse plus a saturating breach counter.
// Ports:
//   Clk, Reset      clock, async active-high reset
//   timer_tick      game time base pulse (ignored in INIT)
//   play_flag       INIT -> PLAY
//   gameover_ctrl   PLAY -> INIT, clears every channel on the same edge
//   q_Init, q_Play  bank state flags
//   bus             shield bank bus (requests/combos/buttons in, status out)
module nexys_starship_shield_bank
  import nexys_starship_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned COMBO_W    = 4,
  parameter int unsigned ARM_TICKS  = 2,
  parameter int unsigned REPAIR_TO  = 30,
  parameter int unsigned MAX_BROKEN = 2,
  parameter int unsigned BREACH_W   = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         timer_tick,
  input  logic                         play_flag,
  input  logic                         gameover_ctrl,
  output logic                         q_Init,
  output logic                         q_Play,
  nexys_starship_shield_bank_if.slave  bus
);

  localparam int unsigned BCNT_MAX = (1 << BREACH_W) - 1;

  bank_state_e bank_q, bank_d;

  logic                    play_active;
  logic                    ch_clear;
  logic [N_CH-1:0]         grant;
  logic [N_CH-1:0]         armed_v;
  logic [N_CH-1:0]         broken_v;
  logic [N_CH-1:0]         repair_ok_v;
  logic [N_CH-1:0]         timeout_v;
  logic [N_CH*COMBO_W-1:0] combo_v;
  logic                    breach_q;
  logic [BREACH_W-1:0]     breach_cnt_q, breach_cnt_d;
  int unsigned             n_broken;
  int unsigned             slots;
  int unsigned             n_to;
  int unsigned             cnt_sum;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) bank_q <= BANK_INIT;
    else       bank_q <= bank_d;
  end

  always_comb begin
    bank_d = bank_q;
    unique case (bank_q)
      BANK_INIT: if (play_flag)     bank_d = BANK_PLAY;
      BANK_PLAY: if (gameover_ctrl) bank_d = BANK_INIT;
      default:                      bank_d = BANK_INIT;
    endcase
  end

  always_comb begin
    q_Init = (bank_q == BANK_INIT);
    q_Play = (bank_q == BANK_PLAY);
  end

  // Game over beats every channel event on the same edge, so channels see
  // it as a clear rather than as play.
  assign play_active = q_Play && !gameover_ctrl;
  assign ch_clear    = !play_active;

  // Budget uses the broken count before this edge's repairs take effect.
  always_comb begin
    grant    = '0;
    n_broken = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (broken_v[i]) n_broken++;
    end
    slots = (n_broken < MAX_BROKEN) ? (MAX_BROKEN - n_broken) : 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (armed_v[i] && bus.break_req[i] && (slots != 0)) begin
        grant[i] = 1'b1;
        slots--;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    nexys_starship_shield_ch #(
      .COMBO_W  (COMBO_W),
      .ARM_TICKS(ARM_TICKS),
      .REPAIR_TO(REPAIR_TO)
    ) u_ch (
      .Clk         (Clk),
      .Reset       (Reset),
      .clear       (ch_clear),
      .active      (play_active),
      .timer_tick  (timer_tick),
      .grant_in    (grant[g]),
      .repair_btn  (bus.repair_btn[g]),
      .override_btn(bus.override_btn),
      .random_hex  (bus.random_hex),
      .hex_combo   (bus.hex_combo),
      .is_armed    (armed_v[g]),
      .is_broken   (broken_v[g]),
      .repair_ok   (repair_ok_v[g]),
      .timeout     (timeout_v[g]),
      .combo       (combo_v[g*COMBO_W +: COMBO_W])
    );
  end

  // Several timeouts on one Clk give a single pulse but count individually.
  always_comb begin
    n_to = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (timeout_v[i]) n_to++;
    end
    cnt_sum      = 32'(breach_cnt_q) + n_to;
    breach_cnt_d = (cnt_sum > BCNT_MAX) ? '1 : BREACH_W'(cnt_sum);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      breach_q     <= 1'b0;
      breach_cnt_q <= '0;
    end else if (!play_active) begin
      breach_q     <= 1'b0;
      breach_cnt_q <= '0;
    end else begin
      breach_q     <= |timeout_v;
      breach_cnt_q <= breach_cnt_d;
    end
  end

  assign bus.broken     = broken_v;
  assign bus.combo_flat = combo_v;
  assign bus.breach     = breach_q;
  assign bus.breach_cnt = breach_cnt_q;

endmodule

// File: tb/tb_nexys_starship_shield_bank.sv
module tb_nexys_starship_shield_bank;

  localparam int N_CH       = 4;
  localparam int COMBO_W    = 4;
  localparam int ARM_TICKS  = 2;
  localparam int REPAIR_TO  = 30;
  localparam int MAX_BROKEN = 2;
  localparam int BREACH_W   = 4;
  localparam int BCNT_SAT   = (1 << BREACH_W) - 1;

  logic Clk = 1'b0;
  logic Reset, timer_tick, play_flag, gameover_ctrl, q_Init, q_Play;

  nexys_starship_shield_bank_if #(.N_CH(N_CH), .COMBO_W(COMBO_W), .BREACH_W(BREACH_W)) bus();

  nexys_starship_shield_bank #(
    .N_CH(N_CH), .COMBO_W(COMBO_W), .ARM_TICKS(ARM_TICKS),
    .REPAIR_TO(REPAIR_TO), .MAX_BROKEN(MAX_BROKEN), .BREACH_W(BREACH_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .timer_tick(timer_tick), .play_flag(play_flag),
    .gameover_ctrl(gameover_ctrl), .q_Init(q_Init), .q_Play(q_Play), .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: per channel a phase (0 waiting to arm, 1 ready, 2 broken),
  // ticks seen in the current phase, and the remembered combo.
  bit               m_play;
  int               m_phase [N_CH];
  int               m_ticks [N_CH];
  logic [COMBO_W-1:0] m_combo [N_CH];
  bit               m_breach;
  int               m_bcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      m_phase[i] = 0;
      m_ticks[i] = 0;
      m_combo[i] = '0;
    end
    m_breach = 0;
    m_bcnt   = 0;
  endtask

  task automatic model_reset();
    m_play = 0;
    model_clear();
  endtask

  // Advance the reference by one Clk using the inputs currently applied.
  task automatic model_step();
    int in_use, budget, expired;
    if (!m_play) begin
      if (play_flag) m_play = 1;
      model_clear();
    end else if (gameover_ctrl) begin
      m_play = 0;
      model_clear();
    end else begin
      in_use = 0;
      for (int i = 0; i < N_CH; i++) if (m_phase[i] == 2) in_use++;
      budget  = MAX_BROKEN - in_use;
      expired = 0;
      for (int i = 0; i < N_CH; i++) begin
        if (m_phase[i] == 0) begin
          if (timer_tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == ARM_TICKS) begin
              m_phase[i] = 1;
              m_ticks[i] = 0;
            end
          end
        end else if (m_phase[i] == 1) begin
          if (bus.break_req[i] && budget > 0) begin
            budget--;
            m_phase[i] = 2;
            m_combo[i] = bus.random_hex;
            m_ticks[i] = 0;
          end
        end else begin
          if (bus.override_btn || (bus.repair_btn[i] && bus.hex_combo == m_combo[i])) begin
            m_phase[i] = 0;
            m_ticks[i] = 0;
          end else if (timer_tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == REPAIR_TO) begin
              m_ticks[i] = 0;
              expired++;
            end
          end
        end
      end
      m_breach = (expired > 0);
      m_bcnt   = (m_bcnt + expired > BCNT_SAT) ? BCNT_SAT : m_bcnt + expired;
    end
  endtask

  task automatic check_outputs(input string where);
    logic [N_CH-1:0]         eb;
    logic [N_CH*COMBO_W-1:0] ec;
    for (int i = 0; i < N_CH; i++) begin
      eb[i] = (m_phase[i] == 2);
      ec[i*COMBO_W +: COMBO_W] = m_combo[i];
    end
    chk({where, ".broken"},     64'(bus.broken),     64'(eb));
    chk({where, ".combo_flat"}, 64'(bus.combo_flat), 64'(ec));
    chk({where, ".breach"},     64'(bus.breach),     64'(m_breach));
    chk({where, ".breach_cnt"}, 64'(bus.breach_cnt), 64'(m_bcnt));
    chk({where, ".q_Init"},     64'(q_Init),         64'(!m_play));
    chk({where, ".q_Play"},     64'(q_Play),         64'(m_play));
  endtask

  task automatic cyc(input string where);
    model_step();
    @(posedge Clk);
    #1;
    check_outputs(where);
  endtask

  task automatic idle_inputs();
    timer_tick        = 0;
    play_flag         = 0;
    gameover_ctrl     = 0;
    bus.break_req     = '0;
    bus.random_hex    = '0;
    bus.hex_combo     = '0;
    bus.repair_btn    = '0;
    bus.override_btn  = 0;
  endtask

  logic [N_CH-1:0] pick;

  initial begin
    idle_inputs();
    Reset = 1;
    model_reset();
    #12;
    check_outputs("reset");
    Reset = 0;
    cyc("post_reset");

    // Start play, two ticks arm every channel, break ch0 with combo A.
    play_flag = 1; cyc("play"); play_flag = 0;
    chk("t1_q_Play", 64'(q_Play), 64'(1));
    timer_tick = 1; cyc("arm1"); cyc("arm2"); timer_tick = 0;
    bus.random_hex = 4'hA; bus.break_req = 4'b0001; cyc("t1_break"); bus.break_req = '0;
    chk("t1_broken0", 64'(bus.broken), 64'(4'b0001));
    chk("t1_combo0",  64'(bus.combo_flat[3:0]), 64'(4'hA));

    // Wrong combo leaves it broken; right combo repairs; rearms after 2 ticks.
    bus.hex_combo = 4'h5; bus.repair_btn = 4'b0001; cyc("t2_wrong"); bus.repair_btn = '0;
    chk("t2_wrong_still_broken", 64'(bus.broken[0]), 64'(1));
    bus.hex_combo = 4'hA; bus.repair_btn = 4'b0001; cyc("t2_right"); bus.repair_btn = '0;
    chk("t2_repaired", 64'(bus.broken[0]), 64'(0));
    chk("t2_combo_kept", 64'(bus.combo_flat[3:0]), 64'(4'hA));
    timer_tick = 1; cyc("t2_rearm1"); cyc("t2_rearm2"); timer_tick = 0;
    bus.random_hex = 4'h3; bus.break_req = 4'b0001; cyc("t2_rebreak"); bus.break_req = '0;
    chk("t2_rebroken", 64'(bus.broken[0]), 64'(1));
    bus.override_btn = 1; cyc("t2_override"); bus.override_btn = 0;

    // Capacity cap and lowest-index-first grants.
    timer_tick = 1; cyc("t3_arm1"); cyc("t3_arm2"); timer_tick = 0;
    bus.random_hex = 4'h7; bus.break_req = 4'b1111; cyc("t3_all_req");
    chk("t3_cap", 64'(bus.broken), 64'(4'b0011));
    bus.hex_combo = 4'h7; bus.repair_btn = 4'b0001; cyc("t3_fix0"); bus.repair_btn = '0;
    chk("t3_after_fix", 64'(bus.broken), 64'(4'b0010));
    cyc("t3_regrant"); bus.break_req = '0;
    chk("t3_grant_ch2", 64'(bus.broken), 64'(4'b0110));

    // Timeout on ch1 alone, then a repair landing on the expiring tick.
    bus.override_btn = 1; cyc("t4_clear"); bus.override_btn = 0;
    timer_tick = 1; cyc("t4_arm1"); cyc("t4_arm2"); timer_tick = 0;
    bus.random_hex = 4'h9; bus.break_req = 4'b0010; cyc("t4_break1"); bus.break_req = '0;
    timer_tick = 1;
    for (int k = 0; k < REPAIR_TO - 1; k++) cyc("t4_wait");
    chk("t4_no_early_breach", 64'(bus.breach), 64'(0));
    cyc("t4_expire");
    chk("t4_breach", 64'(bus.breach), 64'(1));
    chk("t4_breach_cnt", 64'(bus.breach_cnt), 64'(1));
    chk("t4_still_broken", 64'(bus.broken[1]), 64'(1));
    for (int k = 0; k < REPAIR_TO - 1; k++) cyc("t4_wait2");
    chk("t4_pulse_once", 64'(bus.breach), 64'(0));
    bus.hex_combo = 4'h9; bus.repair_btn = 4'b0010; cyc("t4_fix_on_tick"); bus.repair_btn = '0;
    timer_tick = 0;
    chk("t4_fix_no_breach", 64'(bus.breach), 64'(0));
    chk("t4_fix_cnt", 64'(bus.breach_cnt), 64'(1));
    chk("t4_fixed", 64'(bus.broken[1]), 64'(0));

    // Override clears all broken; gameover beats a same-Clk break request.
    bus.break_req = 4'b1111; cyc("t5_fill"); bus.break_req = '0;
    chk("t5_two_broken", 64'(bus.broken), 64'(4'b0101));
    bus.override_btn = 1; cyc("t5_override"); bus.override_btn = 0;
    chk("t5_override_clear", 64'(bus.broken), 64'(0));
    bus.break_req = 4'b1111; gameover_ctrl = 1; cyc("t5_gameover");
    bus.break_req = '0; gameover_ctrl = 0;
    chk("t5_q_Init", 64'(q_Init), 64'(1));
    chk("t5_broken0", 64'(bus.broken), 64'(0));
    chk("t5_cnt0", 64'(bus.breach_cnt), 64'(0));

    // Breach counter saturation: two broken channels time out together.
    play_flag = 1; cyc("t6_play"); play_flag = 0;
    timer_tick = 1; cyc("t6_arm1"); cyc("t6_arm2"); timer_tick = 0;
    bus.break_req = 4'b1111; bus.random_hex = 4'hC; cyc("t6_break"); bus.break_req = '0;
    timer_tick = 1;
    for (int k = 0; k < 8 * REPAIR_TO; k++) cyc("t6_sat");
    timer_tick = 0;
    chk("t6_saturated", 64'(bus.breach_cnt), 64'(BCNT_SAT));

    // Randomized play against the reference.
    for (int k = 0; k < 900; k++) begin
      timer_tick       = ($urandom_range(1, 0) == 1);
      play_flag        = ($urandom_range(3, 0) == 0);
      gameover_ctrl    = ($urandom_range(199, 0) == 0);
      bus.override_btn = ($urandom_range(99, 0) == 0);
      for (int i = 0; i < N_CH; i++) pick[i] = ($urandom_range(3, 0) == 0);
      bus.break_req    = pick;
      bus.random_hex   = COMBO_W'($urandom);
      pick             = '0;
      pick[$urandom_range(N_CH - 1, 0)] = ($urandom_range(2, 0) == 0);
      bus.repair_btn   = pick;
      bus.hex_combo    = COMBO_W'($urandom);
      if ($urandom_range(1, 0) == 1)
        bus.hex_combo = m_combo[$urandom_range(N_CH - 1, 0)];
      cyc("rand");
    end
    idle_inputs();

    // Asynchronous reset while channels are broken.
    if (!m_play) begin
      play_flag = 1; cyc("t7_play"); play_flag = 0;
    end
    timer_tick = 1; cyc("t7_arm1"); cyc("t7_arm2"); timer_tick = 0;
    bus.random_hex = 4'h6; bus.break_req = 4'b1111; cyc("t7_break"); bus.break_req = '0;
    chk("t7_some_broken", 64'(bus.broken != '0), 64'(1));
    #2;
    Reset = 1;
    #1;
    model_reset();
    chk("t7_rst_broken", 64'(bus.broken), 64'(0));
    chk("t7_rst_combo", 64'(bus.combo_flat), 64'(0));
    chk("t7_rst_cnt", 64'(bus.breach_cnt), 64'(0));
    chk("t7_rst_q_Init", 64'(q_Init), 64'(1));
    check_outputs("t7_rst");
    @(posedge Clk); #1;
    Reset = 0;
    cyc("t7_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
